// File: rtl/csr_irq_unit.sv
// Machine-mode CSR file with trap/MRET sequencing, interrupt pending logic and 64-bit cycle/instret counters.
// Latency: one cycle; read_value, fault and irq_pending are registered results of the op presented on the previous edge.
// Backpressure: none; an op is accepted every cycle and non-CSR opcodes are treated as idle.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   op                  000 trap, 001 MRET, 101 CSRRW, 110 CSRRS, 111 CSRRC, others idle
//   addr_exception      CSR address; for a trap [4] = interrupt flag, [3:0] = cause code
//   write_value         CSR operand; for a trap the faulting/interrupted PC
//   retire              one instruction retired this cycle (minstret increment)
//   ext_irq, timer_irq  level interrupt lines, visible live in mip
//   read_value          CSR old value / trap target / MRET target
//   fault               illegal access or idle op
//   irq_pending         MIE & any enabled pending interrupt, from post-update state
module csr_irq_unit #(
   parameter logic [31:0] IRQ_HANDLER_ADDR = 32'h0000_0010,
   parameter bit          VECTORED_EN      = 1'b1,
   parameter bit          COUNTERS_EN      = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [2:0]  op,
   input  logic [11:0] addr_exception,
   input  logic [31:0] write_value,
   input  logic        retire,
   input  logic        ext_irq,
   input  logic        timer_irq,
   output logic [31:0] read_value,
   output logic        fault,
   output logic        irq_pending
);

   localparam logic [2:0] OP_TRAP  = 3'b000;
   localparam logic [2:0] OP_MRET  = 3'b001;
   localparam logic [2:0] OP_CSRRW = 3'b101;
   localparam logic [2:0] OP_CSRRS = 3'b110;
   localparam logic [2:0] OP_CSRRC = 3'b111;

   localparam logic [31:0] MTVEC_RST  = {IRQ_HANDLER_ADDR[31:2], 2'b00};
   // MODE bit survives a write only when vectored mode is built in.
   localparam logic [31:0] MTVEC_MASK = {30'h3FFF_FFFF, 1'b0, VECTORED_EN};

   // Architectural state
   logic        mstat_mie_q, mstat_mpie_q;
   logic [31:0] mie_q;
   logic        msip_q;
   logic [31:0] mtvec_q, mscratch_q, mepc_q, mcause_q;
   logic [63:0] mcycle_q, minstret_q;

   // Next-state values
   logic        mstat_mie_d, mstat_mpie_d;
   logic [31:0] mie_d;
   logic        msip_d;
   logic [31:0] mtvec_d, mscratch_d, mepc_d, mcause_d;
   logic [63:0] mcycle_d, minstret_d;
   logic [31:0] read_value_d;
   logic        fault_d, irq_pending_d;

   // Decode / datapath
   logic [31:0] mstatus_val, mip_live, mip_next;
   logic [31:0] csr_old, csr_new, trap_target;
   logic        csr_known, csr_ro, is_csr_op, wr_intent, csr_wr;

   assign mstatus_val = {24'b0, mstat_mpie_q, 3'b0, mstat_mie_q, 3'b0};
   // MTIP/MEIP are the live input levels; only MSIP is stored.
   assign mip_live    = {20'b0, ext_irq, 3'b0, timer_irq, 3'b0, msip_q, 3'b0};
   assign mip_next    = {20'b0, ext_irq, 3'b0, timer_irq, 3'b0, msip_d, 3'b0};

   assign is_csr_op = (op == OP_CSRRW) || (op == OP_CSRRS) || (op == OP_CSRRC);
   // Set/clear with a zero operand is a pure read and must not trip read-only aliases.
   assign wr_intent = (op == OP_CSRRW) || (is_csr_op && (write_value != 32'd0));
   assign csr_wr    = is_csr_op && csr_known && !csr_ro && wr_intent;

   always_comb begin
      csr_old   = 32'd0;
      csr_known = 1'b0;
      csr_ro    = 1'b0;
      case (addr_exception)
         12'h300: begin csr_old = mstatus_val;        csr_known = 1'b1; end
         12'h304: begin csr_old = mie_q;              csr_known = 1'b1; end
         12'h344: begin csr_old = mip_live;           csr_known = 1'b1; end
         12'h305: begin csr_old = mtvec_q;            csr_known = 1'b1; end
         12'h340: begin csr_old = mscratch_q;         csr_known = 1'b1; end
         12'h341: begin csr_old = mepc_q;             csr_known = 1'b1; end
         12'h342: begin csr_old = mcause_q;           csr_known = 1'b1; end
         12'hB00: begin csr_old = mcycle_q[31:0];     csr_known = COUNTERS_EN; end
         12'hB80: begin csr_old = mcycle_q[63:32];    csr_known = COUNTERS_EN; end
         12'hB02: begin csr_old = minstret_q[31:0];   csr_known = COUNTERS_EN; end
         12'hB82: begin csr_old = minstret_q[63:32];  csr_known = COUNTERS_EN; end
         12'hC00: begin csr_old = mcycle_q[31:0];     csr_known = COUNTERS_EN; csr_ro = 1'b1; end
         12'hC80: begin csr_old = mcycle_q[63:32];    csr_known = COUNTERS_EN; csr_ro = 1'b1; end
         12'hC02: begin csr_old = minstret_q[31:0];   csr_known = COUNTERS_EN; csr_ro = 1'b1; end
         12'hC82: begin csr_old = minstret_q[63:32];  csr_known = COUNTERS_EN; csr_ro = 1'b1; end
         default: ;
      endcase
   end

   always_comb begin
      case (op)
         OP_CSRRS: csr_new = csr_old | write_value;
         OP_CSRRC: csr_new = csr_old & ~write_value;
         default:  csr_new = write_value;
      endcase
   end

   always_comb begin
      trap_target = {mtvec_q[31:2], 2'b00};
      if (VECTORED_EN && mtvec_q[0] && addr_exception[4])
         trap_target = trap_target + {26'b0, addr_exception[3:0], 2'b00};
   end

   always_comb begin
      mstat_mie_d  = mstat_mie_q;
      mstat_mpie_d = mstat_mpie_q;
      mie_d        = mie_q;
      msip_d       = msip_q;
      mtvec_d      = mtvec_q;
      mscratch_d   = mscratch_q;
      mepc_d       = mepc_q;
      mcause_d     = mcause_q;
      mcycle_d     = COUNTERS_EN ? (mcycle_q + 64'd1) : 64'd0;
      minstret_d   = COUNTERS_EN ? (minstret_q + {63'd0, retire}) : 64'd0;
      read_value_d = read_value;
      fault_d      = 1'b1;

      case (op)
         OP_TRAP: begin
            mepc_d       = {write_value[31:2], 2'b00};
            mcause_d     = {addr_exception[4], 27'b0, addr_exception[3:0]};
            mstat_mpie_d = mstat_mie_q;
            mstat_mie_d  = 1'b0;
            read_value_d = trap_target;
            fault_d      = 1'b0;
         end
         OP_MRET: begin
            read_value_d = mepc_q;
            mstat_mie_d  = mstat_mpie_q;
            mstat_mpie_d = 1'b1;
            fault_d      = 1'b0;
         end
         OP_CSRRW, OP_CSRRS, OP_CSRRC: begin
            if (!csr_known) begin
               read_value_d = 32'd0;
               fault_d      = 1'b1;
            end else begin
               read_value_d = csr_old;
               fault_d      = csr_ro && wr_intent;
            end
            if (csr_wr) begin
               case (addr_exception)
                  12'h300: begin
                     mstat_mie_d  = csr_new[3];
                     mstat_mpie_d = csr_new[7];
                  end
                  12'h304: mie_d      = csr_new & 32'h0000_0888;
                  12'h344: msip_d     = csr_new[3];
                  12'h305: mtvec_d    = csr_new & MTVEC_MASK;
                  12'h340: mscratch_d = csr_new;
                  12'h341: mepc_d     = {csr_new[31:2], 2'b00};
                  12'h342: mcause_d   = csr_new & 32'h8000_000F;
                  // A counter write replaces the increment for the whole 64-bit counter.
                  12'hB00: mcycle_d   = {mcycle_q[63:32], csr_new};
                  12'hB80: mcycle_d   = {csr_new, mcycle_q[31:0]};
                  12'hB02: minstret_d = {minstret_q[63:32], csr_new};
                  12'hB82: minstret_d = {csr_new, minstret_q[31:0]};
                  default: ;
               endcase
            end
         end
         default: ;
      endcase

      // Uses post-update MIE, so a trap taken alongside a pending interrupt masks it.
      irq_pending_d = mstat_mie_d & (|(mip_next & mie_d));
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         mstat_mie_q  <= 1'b0;
         mstat_mpie_q <= 1'b0;
         mie_q        <= 32'd0;
         msip_q       <= 1'b0;
         mtvec_q      <= MTVEC_RST;
         mscratch_q   <= 32'd0;
         mepc_q       <= 32'd0;
         mcause_q     <= 32'd0;
         mcycle_q     <= 64'd0;
         minstret_q   <= 64'd0;
         read_value   <= 32'd0;
         fault        <= 1'b0;
         irq_pending  <= 1'b0;
      end else begin
         mstat_mie_q  <= mstat_mie_d;
         mstat_mpie_q <= mstat_mpie_d;
         mie_q        <= mie_d;
         msip_q       <= msip_d;
         mtvec_q      <= mtvec_d;
         mscratch_q   <= mscratch_d;
         mepc_q       <= mepc_d;
         mcause_q     <= mcause_d;
         mcycle_q     <= mcycle_d;
         minstret_q   <= minstret_d;
         read_value   <= read_value_d;
         fault        <= fault_d;
         irq_pending  <= irq_pending_d;
      end
   end

endmodule

// File: doc/csr_irq_unit.md
CSR_IRQ_UNIT -- requirements
Module: csr_irq_unit

Interface
REQ-001 SHALL have parameter IRQ_HANDLER_ADDR, default 32'h00000010, reset value of mtvec base (bits [1:0] ignored).
REQ-002 SHALL have parameter VECTORED_EN, default 1, 1 = mtvec vectored mode (MODE=1) supported.
REQ-003 SHALL have parameter COUNTERS_EN, default 1, 1 = mcycle/minstret implemented; 0 = those addresses fault.
REQ-004 SHALL have ports: clk  in  1  clock; all state updates on rising edge.
REQ-005 SHALL have ports: reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have ports: op  in  3  3'b000 exception/trap, 3'b001 MRET, 3'b101 CSRRW, 3'b110 CSRRS, 3'b111 CSRRC; others idle.
REQ-007 SHALL have ports: addr_exception  in  12  CSR address; for trap, [4] interrupt flag, [3:0] cause code.
REQ-008 SHALL have ports: write_value  in  32  CSR write operand; for trap, faulting/interrupted PC.
REQ-009 SHALL have ports: retire  in  1  one instruction retired this cycle.
REQ-010 SHALL have ports: ext_irq, timer_irq  in  1 each  level-sensitive external and timer interrupt lines.
REQ-011 SHALL have ports: read_value  out  32  registered CSR old value / trap target / MRET target.
REQ-012 SHALL have ports: fault  out  1  registered illegal-access / idle flag.
REQ-013 SHALL have ports: irq_pending  out  1  registered: interrupt should be taken.

Function
REQ-014 All outputs and state SHALL be registered; read_value/fault reflect the op one cycle later.
REQ-015 Write intent SHALL be: CSRRW always; CSRRS/CSRRC only when write_value != 0.
REQ-016 CSRRW SHALL set field = wv; CSRRS field |= wv; CSRRC field &= ~wv; read_value = pre-update value.
REQ-017 Trap SHALL: mepc <= {write_value[31:2],2'b0}; mcause <= {addr_exception[4],27'b0,addr_exception[3:0]}; MPIE <= MIE; MIE <= 0; fault <= 0.
REQ-018 Trap target SHALL be {base,2'b00}; if VECTORED_EN and mtvec.MODE=1 and interrupt flag set, target = base + 4*code (mod 2^32).
REQ-019 MRET SHALL: read_value <= mepc; MIE <= MPIE; MPIE <= 1; fault <= 0.
REQ-020 mstatus 0x300: MIE bit3, MPIE bit7 writable; other bits read 0.
REQ-021 mie 0x304: MSIE bit3, MTIE bit7, MEIE bit11 writable.
REQ-022 mip 0x344: MSIP bit3 software-writable; MTIP bit7 = timer_irq, MEIP bit11 = ext_irq, sampled each cycle, writes ignored, no fault.
REQ-023 mtvec 0x305: bits[31:2] writable; MODE bit0 writable only if VECTORED_EN, else reads 0; bit1 reads 0.
REQ-024 mscratch 0x340: full 32-bit RW.
REQ-025 mepc 0x341: RW, bits[1:0] forced 0; mcause 0x342: RW, only bits 31 and [3:0] stored.
REQ-026 mcycle 0xB00/0xB80 and minstret 0xB02/0xB82: RW low/high halves of 64-bit counters.
REQ-027 cycle 0xC00/0xC80, instret 0xC02/0xC82: read-only aliases; write intent SHALL fault, no state change.
REQ-028 mcycle SHALL increment by 1 every non-reset cycle; minstret by 1 when retire=1; carry low->high; 2^64-1 wraps to 0.
REQ-029 A CSR write to a counter half SHALL override that cycle's increment for the whole counter (written half takes wv, other half holds).
REQ-030 Unknown address SHALL give read_value 0, fault 1, no state change; idle op SHALL give fault 1, read_value hold.
REQ-031 irq_pending SHALL be registered MIE & |(mip & mie) computed from the post-update values of this cycle.
REQ-032 A trap on the same cycle as a sampled interrupt SHALL clear MIE, so irq_pending = 0 next cycle.

Reset
REQ-033 On reset: read_value 0, fault 0, irq_pending 0, mtvec = {IRQ_HANDLER_ADDR[31:2],2'b00}, all other CSRs and counters 0.
REQ-034 Reset SHALL override any concurrent op, retire, or interrupt input.

Verification
REQ-035 CSRRW 0x340 wv=32'hDEADBEEF, then CSRRS 0x340 wv=0 -> read_value 32'hDEADBEEF, fault 0.
REQ-036 mtvec=32'h00000101, trap addr_exception=12'h01B (irq, code 11), pc 32'h80 -> read_value 32'h0000012C, mepc 32'h80, mcause 32'h8000000B.
REQ-037 MIE=1, MEIE=1, ext_irq=1 -> irq_pending 1 the following cycle; after trap -> 0; MRET -> MIE 1, read_value = mepc.
REQ-038 CSRRW 0xB00 wv=32'hFFFFFFFF then idle 2 cycles -> mcycleh 1, mcycle low 1.
REQ-039 CSRRW 0xC00 wv=5 -> fault 1, counter unaffected; CSRRS 0xC00 wv=0 -> fault 0.
REQ-040 Reset asserted mid CSRRW 0x340 -> mscratch 0, fault 0, mtvec = default.
